// File: rtl/mod_updown_counter_pkg.sv
// rtl/mod_updown_counter_pkg.sv - shared constants and reset-value helper for the bounded counter
package counter_pkg;

  localparam logic SAT_MODE  = 1'b1;
  localparam logic WRAP_MODE = 1'b0;

  // Zero when the range contains it, otherwise the lower bound.
  function automatic int reset_val(input int min_v, input int max_v);
    return (min_v <= 0 && max_v >= 0) ? 0 : min_v;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// rtl/mod_updown_counter_if.sv - control and status bundle for mod_updown_counter
interface mod_updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic                    en;
  logic                    up;
  logic [STEP_W-1:0]       step;
  logic                    sat;
  logic                    load;
  logic signed [WIDTH-1:0] load_val;
  logic                    ovf_clr;
  logic signed [WIDTH-1:0] q;
  logic                    tc;
  logic                    ovf;

  modport master (
    output en, up, step, sat, load, load_val, ovf_clr,
    input  q, tc, ovf
  );

  modport slave (
    input  en, up, step, sat, load, load_val, ovf_clr,
    output q, tc, ovf
  );
endinterface

// File: rtl/mod_updown_counter_bounded_step.sv
// rtl/mod_updown_counter_bounded_step.sv - combinational bounded step with wrap/saturate and event flag
module bounded_step
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = -(2**(WIDTH-1)),
  parameter int MAX_VAL = 2**(WIDTH-1)-1,
  parameter int STEP_W  = 4
) (
  input  logic signed [WIDTH-1:0] q,
  input  logic [STEP_W-1:0]       step,
  input  logic                    up,
  input  logic                    sat,
  output logic signed [WIDTH-1:0] next_q,
  output logic                    evt
);
  // Wide enough that q +/- step never overflows before the bound compare.
  localparam int RW = WIDTH + STEP_W + 1;
  localparam logic signed [RW-1:0] MIN_R   = RW'(MIN_VAL);
  localparam logic signed [RW-1:0] MAX_R   = RW'(MAX_VAL);
  localparam logic signed [RW-1:0] RANGE_R = RW'(MAX_VAL - MIN_VAL + 1);

  logic signed [RW-1:0] q_x;
  logic signed [RW-1:0] step_x;
  logic signed [RW-1:0] raw;
  logic signed [RW-1:0] adj;

  always_comb begin
    q_x    = RW'(q);
    step_x = RW'(step);
    if (step_x > RANGE_R) step_x = RANGE_R;
    raw    = up ? (q_x + step_x) : (q_x - step_x);
    adj    = raw;
    evt    = 1'b0;
    if (up && raw > MAX_R) begin
      evt = 1'b1;
      adj = (sat == SAT_MODE) ? MAX_R : (raw - RANGE_R);
    end else if (!up && raw < MIN_R) begin
      evt = 1'b1;
      adj = (sat == SAT_MODE) ? MIN_R : (raw + RANGE_R);
    end
    next_q = adj[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - signed up/down counter with range, variable step, load and overflow flags
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = -(2**(WIDTH-1)),
  parameter int MAX_VAL = 2**(WIDTH-1)-1,
  parameter int STEP_W  = 4
) (
  input  logic                clk,
  input  logic                clr,
  mod_updown_counter_if.slave bus
);
  localparam logic signed [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH-1:0] RST_W = WIDTH'(reset_val(MIN_VAL, MAX_VAL));

  logic signed [WIDTH-1:0] q_r;
  logic                    tc_r;
  logic                    ovf_r;
  logic signed [WIDTH-1:0] next_q;
  logic                    evt;
  logic signed [WIDTH-1:0] load_clamped;

  bounded_step #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL),
    .STEP_W (STEP_W)
  ) u_step (
    .q     (q_r),
    .step  (bus.step),
    .up    (bus.up),
    .sat   (bus.sat),
    .next_q(next_q),
    .evt   (evt)
  );

  always_comb begin
    load_clamped = bus.load_val;
    if (bus.load_val < MIN_W) load_clamped = MIN_W;
    else if (bus.load_val > MAX_W) load_clamped = MAX_W;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_r   <= RST_W;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (bus.load) begin
        q_r <= load_clamped;
      end else if (bus.en) begin
        q_r  <= next_q;
        tc_r <= evt;
      end
      // A same-edge event outranks ovf_clr.
      if (bus.en && !bus.load && evt) ovf_r <= 1'b1;
      else if (bus.ovf_clr)           ovf_r <= 1'b0;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;

endmodule
